// File: rtl/mmcm_drp_sequencer_pkg.sv
// Shared clock-configuration parameters: the config ROM entry layout and the
// sequencer defaults used by mmcm_drp_sequencer.
package mmcm_drp_sequencer_pkg;

  localparam int unsigned BRAM_CNT_SELECT_CLOCK = 2;

  localparam int unsigned ROM_AW = 5;
  localparam int unsigned ROM_DW = 39;
  localparam int unsigned DRP_AW = 7;
  localparam int unsigned DRP_DW = 16;

  // Entry 31 is a table-level marker; bit 0 says the ROM holds a usable config.
  localparam int unsigned ROM_VALID_IDX = 31;
  localparam int unsigned ROM_VALID_BIT = 0;

  localparam int unsigned N_ENTRIES_DEFAULT  = 23;
  localparam int unsigned LOCK_IGNORE_CYCLES = 2;

  // Field positions: {DRP addr[38:32], keep-mask[31:16], set-data[15:0]}
  typedef struct packed {
    logic [DRP_AW-1:0] daddr;
    logic [DRP_DW-1:0] mask;
    logic [DRP_DW-1:0] data;
  } rom_entry_t;

  // Mask bits keep the current register contents; cleared bits take ROM data.
  function automatic logic [DRP_DW-1:0] drp_merge(
    input logic [DRP_DW-1:0] rd,
    input logic [DRP_DW-1:0] mask,
    input logic [DRP_DW-1:0] data
  );
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/mmcm_drp_sequencer.sv
// Applies a clock-config ROM to an MMCM over DRP: read-modify-write per entry
// while the MMCM is held in reset, then waits for lock.
module mmcm_drp_sequencer
  import mmcm_drp_sequencer_pkg::*;
#(
  parameter int unsigned N_ENTRIES    = N_ENTRIES_DEFAULT,
  parameter int unsigned DRDY_TIMEOUT = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic [ROM_AW-1:0] ROM_ADDR,
  input  logic [ROM_DW-1:0] ROM_DATA,
  output logic [DRP_AW-1:0] DADDR,
  output logic [DRP_DW-1:0] DI,
  input  logic [DRP_DW-1:0] DO,
  output logic              DEN,
  output logic              DWE,
  input  logic              DRDY,
  input  logic              LOCKED,
  output logic              MMCM_RST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR
);

  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  DRDY_LAST  = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LOCK_BLANK = CNT_W'(LOCK_IGNORE_CYCLES);
  localparam logic [ROM_AW-1:0] LAST_IDX   = ROM_AW'(N_ENTRIES - 1);
  localparam logic [ROM_AW-1:0] VALID_ADDR = ROM_AW'(ROM_VALID_IDX);

  typedef enum logic [3:0] {
    IDLE,
    CHK_RD,
    CHK,
    RST_ON,
    ROM_RD,
    DRP_RD,
    WAIT_RD,
    DRP_WR,
    WAIT_WR,
    RST_OFF,
    WAIT_LOCK,
    FIN
  } state_t;

  state_t            state;
  logic [ROM_AW-1:0] entry_idx;
  logic              rom_wait;
  logic [DRP_DW-1:0] entry_mask;
  logic [DRP_DW-1:0] entry_data;
  logic [CNT_W-1:0]  cnt;
  rom_entry_t        rom_entry;

  assign rom_entry = ROM_DATA;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      entry_idx  <= '0;
      rom_wait   <= 1'b0;
      entry_mask <= '0;
      entry_data <= '0;
      cnt        <= '0;
      ROM_ADDR   <= '0;
      DADDR      <= '0;
      DI         <= '0;
      DEN        <= 1'b0;
      DWE        <= 1'b0;
      MMCM_RST   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            ERROR    <= 1'b0;
            BUSY     <= 1'b1;
            ROM_ADDR <= VALID_ADDR;
            state    <= CHK_RD;
          end
        end

        CHK_RD: state <= CHK;

        CHK: begin
          if (ROM_DATA[ROM_VALID_BIT]) begin
            state <= RST_ON;
          end else begin
            ERROR <= 1'b1;
            state <= FIN;
          end
        end

        RST_ON: begin
          MMCM_RST  <= 1'b1;
          entry_idx <= '0;
          ROM_ADDR  <= '0;
          rom_wait  <= 1'b0;
          state     <= ROM_RD;
        end

        // Two cycles: address goes out, then the BRAM output is valid and the
        // read strobe is launched with the entry's DRP address.
        ROM_RD: begin
          if (!rom_wait) begin
            rom_wait <= 1'b1;
          end else begin
            rom_wait   <= 1'b0;
            entry_mask <= rom_entry.mask;
            entry_data <= rom_entry.data;
            DADDR      <= rom_entry.daddr;
            DEN        <= 1'b1;
            DWE        <= 1'b0;
            cnt        <= '0;
            state      <= DRP_RD;
          end
        end

        DRP_RD: begin
          DEN   <= 1'b0;
          cnt   <= cnt + 1'b1;
          state <= WAIT_RD;
        end

        WAIT_RD: begin
          if (DRDY) begin
            DI    <= drp_merge(DO, entry_mask, entry_data);
            DEN   <= 1'b1;
            DWE   <= 1'b1;
            cnt   <= '0;
            state <= DRP_WR;
          end else if (cnt >= DRDY_LAST) begin
            ERROR <= 1'b1;
            state <= RST_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DRP_WR: begin
          DEN   <= 1'b0;
          DWE   <= 1'b0;
          cnt   <= cnt + 1'b1;
          state <= WAIT_WR;
        end

        WAIT_WR: begin
          if (DRDY) begin
            if (entry_idx == LAST_IDX) begin
              state <= RST_OFF;
            end else begin
              entry_idx <= entry_idx + 1'b1;
              ROM_ADDR  <= entry_idx + 1'b1;
              state     <= ROM_RD;
            end
          end else if (cnt >= DRDY_LAST) begin
            ERROR <= 1'b1;
            state <= RST_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RST_OFF: begin
          MMCM_RST <= 1'b0;
          cnt      <= '0;
          state    <= WAIT_LOCK;
        end

        // LOCKED may still reflect the pre-reset lock right after release.
        WAIT_LOCK: begin
          if (LOCKED && (cnt >= LOCK_BLANK)) begin
            state <= FIN;
          end else if (cnt >= LOCK_LAST) begin
            ERROR <= 1'b1;
            state <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FIN: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Self-checking bench for mmcm_drp_sequencer: BRAM, DRP and MMCM lock models
// with a DRP transaction scoreboard.
module tb_mmcm_drp_sequencer;
  import mmcm_drp_sequencer_pkg::*;

  localparam int unsigned N        = 23;
  localparam int unsigned DRDY_TO  = 255;
  localparam int unsigned LOCK_TO  = 65535;
  localparam int unsigned LOCK_DLY = 6;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [4:0]  ROM_ADDR;
  logic [38:0] ROM_DATA = '0;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic [15:0] DO = '0;
  logic        DEN;
  logic        DWE;
  logic        DRDY = 1'b0;
  logic        LOCKED = 1'b0;
  logic        MMCM_RST;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  mmcm_drp_sequencer #(
    .N_ENTRIES   (N),
    .DRDY_TIMEOUT(DRDY_TO),
    .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .ROM_ADDR(ROM_ADDR),
    .ROM_DATA(ROM_DATA),
    .DADDR   (DADDR),
    .DI      (DI),
    .DO      (DO),
    .DEN     (DEN),
    .DWE     (DWE),
    .DRDY    (DRDY),
    .LOCKED  (LOCKED),
    .MMCM_RST(MMCM_RST),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERROR   (ERROR)
  );

  always #5 CLK = ~CLK;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // BRAM read port with 1-cycle latency
  logic [38:0] rom [32];
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  // DRP model: DRDY one cycle after DEN, optionally withheld for one read address
  logic [6:0] withhold_addr = 7'h7F;
  always @(posedge CLK) begin
    DRDY <= 1'b0;
    if (DEN && !(!DWE && DADDR == withhold_addr)) DRDY <= 1'b1;
  end

  // MMCM lock model
  int unsigned lk_cnt = 0;
  logic lock_hold = 1'b0;
  always @(posedge CLK) begin
    if (MMCM_RST || lock_hold) begin
      lk_cnt <= 0;
      LOCKED <= 1'b0;
    end else if (lk_cnt < LOCK_DLY) begin
      lk_cnt <= lk_cnt + 1;
    end else begin
      LOCKED <= 1'b1;
    end
  end

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
  } drp_txn_t;

  drp_txn_t exp_q[$];

  int unsigned den_cnt = 0, rst_cnt = 0, done_cnt = 0;
  int unsigned done_cyc = 0, err_cyc = 0, rel_cyc = 0, den5_cyc = 0;
  logic prev_rst = 1'b0, prev_err = 1'b0, pending = 1'b0;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (DRDY) pending = 1'b0;
      if (DEN) begin
        drp_txn_t t;
        den_cnt++;
        check("den_before_drdy", 64'(pending), 64'(0));
        pending = 1'b1;
        if (!DWE && DADDR == 7'h0D) den5_cyc = cyc;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_den: got addr 0x%0h we %0d expected no access", DADDR, DWE);
        end else begin
          t = exp_q.pop_front();
          check("den_we", 64'(DWE), 64'(t.we));
          check("den_addr", 64'(DADDR), 64'(t.addr));
          if (t.we) check("den_di", 64'(DI), 64'(t.di));
        end
      end
      if (MMCM_RST) rst_cnt++;
      if (prev_rst && !MMCM_RST) rel_cyc = cyc;
      if (ERROR && !prev_err) err_cyc = cyc;
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
        pending  = 1'b0;
      end
    end
    prev_rst = MMCM_RST;
    prev_err = ERROR;
  end

  task automatic load_rom(input logic [15:0] mask, input logic [15:0] data, input logic valid);
    for (int unsigned i = 0; i < 31; i++) rom[i] = {7'(8 + i), mask, data};
    rom[31] = {38'b0, valid};
  endtask

  task automatic push_seq(input int unsigned n_full, input logic [15:0] di, input bit last_read);
    for (int unsigned i = 0; i < n_full; i++) begin
      exp_q.push_back({1'b0, 7'(8 + i), 16'h0000});
      exp_q.push_back({1'b1, 7'(8 + i), di});
    end
    if (last_read) exp_q.push_back({1'b0, 7'(8 + n_full), 16'h0000});
  endtask

  int unsigned start_cyc = 0;

  task automatic do_start();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned d0 = done_cnt;
    for (int unsigned k = 0; k < budget && done_cnt == d0; k++) begin
      @(negedge CLK);
      #1;
    end
    check("done_within_budget", 64'(done_cnt != d0), 64'(1));
  endtask

  task automatic clear_counts();
    den_cnt = 0;
    rst_cnt = 0;
    done_cnt = 0;
  endtask

  typedef struct {
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] do_v;
    logic [15:0] exp_di;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int unsigned lat;
    bit found;

    vecs[0] = '{16'hFFFF, 16'h0000, 16'h1234, 16'h1234};
    vecs[1] = '{16'h8000, 16'h7ABC, 16'hFFFF, 16'hFABC};
    vecs[2] = '{16'h0000, 16'hA5A5, 16'h1234, 16'hA5A5};
    vecs[3] = '{16'h00FF, 16'h1200, 16'h5634, 16'h1234};

    load_rom(16'hFFFF, 16'h0000, 1'b1);
    repeat (3) @(negedge CLK);
    check("rst_rom_addr", 64'(ROM_ADDR), 64'(0));
    check("rst_drp", 64'({DADDR, DI, DEN, DWE}), 64'(0));
    check("rst_flags", 64'({MMCM_RST, BUSY, DONE, ERROR}), 64'(0));
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Table-driven full sequences: read-modify-write merge per row
    for (int unsigned r = 0; r < 4; r++) begin
      load_rom(vecs[r].mask, vecs[r].data, 1'b1);
      DO = vecs[r].do_v;
      clear_counts();
      push_seq(N, vecs[r].exp_di, 1'b0);
      do_start();
      check("busy_after_start", 64'(BUSY), 64'(1));
      wait_done(1000);
      lat = done_cyc - start_cyc;
      // 4 + 23*6 + lock wait (LOCK_DLY+2 cycles in WAIT_LOCK) + 2, +/-1
      check("latency_window", 64'((lat + 1 >= 4 + N * 6 + LOCK_DLY + 4) && (lat <= 4 + N * 6 + LOCK_DLY + 5)), 64'(1));
      check("seq_error", 64'(ERROR), 64'(0));
      check("seq_den_count", 64'(den_cnt), 64'(2 * N));
      check("seq_queue_empty", 64'(exp_q.size()), 64'(0));
      @(negedge CLK);
      check("seq_done_pulses", 64'(done_cnt), 64'(1));
      check("seq_idle", 64'({BUSY, MMCM_RST}), 64'(0));
    end

    // Invalid ROM: error with no DRP access and no MMCM reset
    load_rom(16'hFFFF, 16'h0000, 1'b0);
    clear_counts();
    do_start();
    wait_done(50);
    check("inval_latency", 64'(done_cyc - start_cyc), 64'(3));
    check("inval_error", 64'(ERROR), 64'(1));
    check("inval_den", 64'(den_cnt), 64'(0));
    check("inval_mmcm_rst", 64'(rst_cnt), 64'(0));

    // DRDY withheld on entry 5 read
    load_rom(16'hFFFF, 16'h0000, 1'b1);
    DO = 16'h1234;
    withhold_addr = 7'h0D;
    clear_counts();
    push_seq(5, 16'h1234, 1'b1);
    do_start();
    check("error_cleared_by_start", 64'(ERROR), 64'(0));
    wait_done(2000);
    check("to_error", 64'(ERROR), 64'(1));
    check("to_error_delay", 64'(err_cyc - den5_cyc), 64'(DRDY_TO));
    check("to_den_count", 64'(den_cnt), 64'(11));
    check("to_queue_empty", 64'(exp_q.size()), 64'(0));
    check("to_mmcm_released", 64'(MMCM_RST), 64'(0));
    check("to_done_pulses", 64'(done_cnt), 64'(1));
    withhold_addr = 7'h7F;

    // Reset mid-sequence at entry 10, then restart from entry 0
    clear_counts();
    push_seq(N, 16'h1234, 1'b0);
    do_start();
    found = 0;
    for (int unsigned k = 0; k < 1000 && !found; k++) begin
      @(negedge CLK);
      #1;
      if (DEN && !DWE && DADDR == 7'h12) found = 1;
    end
    check("mid_reached_entry10", 64'(found), 64'(1));
    RST_N = 1'b0;
    #1;
    check("mid_rst_rom_addr", 64'(ROM_ADDR), 64'(0));
    check("mid_rst_drp", 64'({DADDR, DI, DEN, DWE}), 64'(0));
    check("mid_rst_flags", 64'({MMCM_RST, BUSY, DONE, ERROR}), 64'(0));
    exp_q.delete();
    pending = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    clear_counts();
    push_seq(N, 16'h1234, 1'b0);
    do_start();
    wait_done(1000);
    check("restart_queue_empty", 64'(exp_q.size()), 64'(0));
    check("restart_den_count", 64'(den_cnt), 64'(2 * N));
    check("restart_error", 64'(ERROR), 64'(0));

    // LOCKED held low: lock timeout, second START during BUSY ignored
    lock_hold = 1'b1;
    clear_counts();
    push_seq(N, 16'h1234, 1'b0);
    do_start();
    repeat (20) @(negedge CLK);
    check("lk_busy", 64'(BUSY), 64'(1));
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(LOCK_TO + 2000);
    check("lk_error", 64'(ERROR), 64'(1));
    check("lk_error_delay", 64'(err_cyc - rel_cyc), 64'(LOCK_TO));
    check("lk_done_window", 64'((done_cyc - rel_cyc + 1 >= LOCK_TO) && (done_cyc - rel_cyc <= LOCK_TO + 1)), 64'(1));
    check("lk_queue_empty", 64'(exp_q.size()), 64'(0));
    repeat (10) @(negedge CLK);
    check("lk_den_count", 64'(den_cnt), 64'(2 * N));
    check("lk_idle", 64'(BUSY), 64'(0));
    check("lk_done_pulses", 64'(done_cnt), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
